// File: rtl/sprite_pkg.sv
// Sprite record exchanged between game logic and the renderer, playfield
// decoration constants, colour type and the rectangle hit-test helper.
package sprite_pkg;
    import vga_pkg::*;

    localparam int SCREEN_BORDER        = 10;
    localparam int SEPARATOR_WIDTH      = 6;
    localparam int SEPARATOR_DOT_HEIGHT = 18;
    localparam int DOT_CNT_W            = $clog2(SEPARATOR_DOT_HEIGHT);

    localparam int COLOR_W = 12;
    typedef logic [COLOR_W-1:0] color_t;

    // Rectangle with exclusive right/bottom edges.
    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    // A sprite with right <= x_pos or bottom <= y_pos can never satisfy both
    // bounds, so empty sprites need no special case.
    function automatic logic sprite_hit(input sprite_t s,
                                        input logic [X_POS_W-1:0] x,
                                        input logic [Y_POS_W-1:0] y);
        return (x >= s.x_pos) && (x < s.right) &&
               (y >= s.y_pos) && (y < s.bottom);
    endfunction
endpackage

// File: rtl/vga_pkg.sv
// Screen geometry and beam-position widths shared by the VGA timing
// generator and everything that consumes its beam coordinates.
package vga_pkg;
    localparam int SCREEN_H_RES = 640;
    localparam int SCREEN_V_RES = 480;
    localparam int X_POS_W      = 10;
    localparam int Y_POS_W      = 10;
endpackage

// File: rtl/sprite_hit_reg.sv
// One sprite lane of the renderer: holds the per-frame shadow copy of a
// sprite record and registers whether the current beam position hits it.
// Ports:
//   clk_i, rst_i  pixel clock, synchronous active-high reset
//   load_i        capture sprite_i into the shadow copy (frame start)
//   sprite_i      live sprite record from game logic
//   x_pos_i       beam column
//   y_pos_i       beam row
//   hit_o         registered hit flag (one cycle after the beam position)
module sprite_hit_reg
    import vga_pkg::*;
    import sprite_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  sprite_t            sprite_i,
    input  logic [X_POS_W-1:0] x_pos_i,
    input  logic [Y_POS_W-1:0] y_pos_i,
    output logic               hit_o
);
    sprite_t r_shadow;
    logic    r_hit;

    // The hit test always uses the shadow value held before this edge, so a
    // load coinciding with a visible pixel still renders that pixel from the
    // previous frame's record.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow <= '0;
            r_hit    <= 1'b0;
        end else begin
            r_hit <= sprite_hit(r_shadow, x_pos_i, y_pos_i);
            if (load_i) begin
                r_shadow <= sprite_i;
            end
        end
    end

    assign hit_o = r_hit;
endmodule

// File: rtl/sprite_renderer.sv
// Pixel renderer for the pong playfield. Snapshots player/enemy/ball sprite
// records at frame start, draws sprites, top/bottom borders and a dotted
// centre separator, and outputs a colour two clocks after the beam position,
// with hsync/vsync/visible delayed to match.
// Ports:
//   clk_i, rst_i               pixel clock, synchronous active-high reset
//   x_pos_i, y_pos_i           beam position
//   visible_i                  beam inside active area
//   hsync_i, vsync_i           syncs from the timing generator
//   frame_start_i              one-cycle pulse in vblank before row 0
//   player_i, enemy_i, ball_i  live sprite records
//   rgb_o                      pixel colour (0 while blanked)
//   hsync_o, vsync_o, visible_o  inputs delayed to align with rgb_o
module sprite_renderer
    import vga_pkg::*;
    import sprite_pkg::*;
#(
    parameter int                 COLOR_W    = sprite_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] FG_COLOR   = '1,
    parameter logic [COLOR_W-1:0] BG_COLOR   = '0,
    parameter logic [COLOR_W-1:0] BALL_COLOR = '1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [X_POS_W-1:0] x_pos_i,
    input  logic [Y_POS_W-1:0] y_pos_i,
    input  logic               visible_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               frame_start_i,
    input  sprite_t            player_i,
    input  sprite_t            enemy_i,
    input  sprite_t            ball_i,
    output logic [COLOR_W-1:0] rgb_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               visible_o
);
    localparam logic [X_POS_W-1:0] SEP_X_LO =
        X_POS_W'(SCREEN_H_RES / 2 - SEPARATOR_WIDTH / 2);
    localparam logic [X_POS_W-1:0] SEP_X_HI =
        X_POS_W'(SCREEN_H_RES / 2 + SEPARATOR_WIDTH / 2);
    localparam logic [Y_POS_W-1:0] BORDER_TOP = Y_POS_W'(SCREEN_BORDER);
    localparam logic [Y_POS_W-1:0] BORDER_BOT = Y_POS_W'(SCREEN_V_RES - SCREEN_BORDER);
    localparam logic [DOT_CNT_W-1:0] DOT_LAST = DOT_CNT_W'(SEPARATOR_DOT_HEIGHT - 1);

    // Sprite lanes: 0 = player, 1 = enemy, 2 = ball.
    localparam int N_SPRITES = 3;
    localparam int IDX_BALL  = 2;

    sprite_t w_sprites [N_SPRITES];
    logic [N_SPRITES-1:0] w_hit;

    assign w_sprites[0] = player_i;
    assign w_sprites[1] = enemy_i;
    assign w_sprites[2] = ball_i;

    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_sprite
        sprite_hit_reg u_hit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .load_i   (frame_start_i),
            .sprite_i (w_sprites[gi]),
            .x_pos_i  (x_pos_i),
            .y_pos_i  (y_pos_i),
            .hit_o    (w_hit[gi])
        );
    end

    // Separator dot pattern. The counter holds the number of rows already
    // finished inside the current dot; it advances at the first pixel of
    // every visible row except row 0, so each dot covers exactly
    // SEPARATOR_DOT_HEIGHT rows starting at the top of the screen.
    logic [DOT_CNT_W-1:0] r_dot_cnt;
    logic                 r_dot_on;
    logic                 w_row_advance;

    assign w_row_advance = visible_i && (x_pos_i == '0) && (y_pos_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || frame_start_i) begin
            r_dot_cnt <= '0;
            r_dot_on  <= 1'b1;
        end else if (w_row_advance) begin
            if (r_dot_cnt == DOT_LAST) begin
                r_dot_cnt <= '0;
                r_dot_on  <= ~r_dot_on;
            end else begin
                r_dot_cnt <= r_dot_cnt + 1'b1;
            end
        end
    end

    logic w_border;
    logic w_sep;

    assign w_border = (y_pos_i < BORDER_TOP) || (y_pos_i >= BORDER_BOT);
    assign w_sep    = r_dot_on && (x_pos_i >= SEP_X_LO) && (x_pos_i < SEP_X_HI);

    // Stage 1: decoration flags and delayed syncs (sprite flags live in the lanes).
    logic r_border_s1, r_sep_s1, r_vis_s1, r_hs_s1, r_vs_s1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_border_s1 <= 1'b0;
            r_sep_s1    <= 1'b0;
            r_vis_s1    <= 1'b0;
            r_hs_s1     <= 1'b0;
            r_vs_s1     <= 1'b0;
        end else begin
            r_border_s1 <= w_border;
            r_sep_s1    <= w_sep;
            r_vis_s1    <= visible_i;
            r_hs_s1     <= hsync_i;
            r_vs_s1     <= vsync_i;
        end
    end

    // Stage 2: colour select with fixed priority, forced black while blanked.
    logic [COLOR_W-1:0] w_color;

    always_comb begin
        w_color = BG_COLOR;
        if (w_hit[IDX_BALL]) begin
            w_color = BALL_COLOR;
        end else if (w_hit[0] || w_hit[1] || r_border_s1 || r_sep_s1) begin
            w_color = FG_COLOR;
        end
        if (!r_vis_s1) begin
            w_color = '0;
        end
    end

    logic [COLOR_W-1:0] r_rgb;
    logic               r_vis_s2, r_hs_s2, r_vs_s2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rgb    <= '0;
            r_vis_s2 <= 1'b0;
            r_hs_s2  <= 1'b0;
            r_vs_s2  <= 1'b0;
        end else begin
            r_rgb    <= w_color;
            r_vis_s2 <= r_vis_s1;
            r_hs_s2  <= r_hs_s1;
            r_vs_s2  <= r_vs_s1;
        end
    end

    assign rgb_o     = r_rgb;
    assign hsync_o   = r_hs_s2;
    assign vsync_o   = r_vs_s2;
    assign visible_o = r_vis_s2;
endmodule
